iiitb_usr_burst: RTL and testbench
==================================

Name: iiitb_usr_burst

Overview:
- Parametrised universal shift register: WIDTH-bit register with load, logical shift, rotate and arithmetic shift, each by a 0..WIDTH-1 bit amount in one cycle (barrel).
- Adds serial in/out for chaining.
- Adds an autonomous burst engine: repeats one latched operation a programmed number of times, with busy/done handshake.
- Sits in the datapath wherever a scrambler, serialiser or bit-alignment stage needs a configurable shifter.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 8, width of the burst repeat count.
- AMT_W (localparam), $clog2(WIDTH), width of the shift amount.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  single-step enable; applies mode/amt this cycle (IDLE only).
- mode  in  3  operation select (encoding below).
- amt  in  AMT_W  shift/rotate amount.
- d  in  WIDTH  parallel load data.
- sin_l  in  1  fill bit entering at MSB side for SRL.
- sin_r  in  1  fill bit entering at LSB side for SLL.
- start  in  1  launch burst (IDLE only).
- cnt  in  CNT_W  burst repeat count, sampled with start.
- abort  in  1  synchronous burst cancel.
- q  out  WIDTH  register contents.
- sout_l  out  1  q[WIDTH-1], combinational from q.
- sout_r  out  1  q[0], combinational from q.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values: q=0, busy=0, done=0, state=IDLE, remaining count=0, latched op=0.
- Mode encoding (shared package):
  - 000 HOLD: q unchanged.
  - 001 SRL: shift right by amt; vacated MSBs filled with sin_l.
  - 010 SLL: shift left by amt; vacated LSBs filled with sin_r.
  - 011 ROR: rotate right by amt.
  - 100 ROL: rotate left by amt.
  - 101 ASR: shift right by amt with sign (q[WIDTH-1]) fill.
  - 110 LOAD: q <= d.
  - 111 reserved: treated as HOLD.
- amt=0 leaves q unchanged for every shift/rotate mode. amt is ignored for LOAD and HOLD.
- IDLE: on the edge where en=1 and start=0, q <= f(q, mode, amt); latency 1 cycle. en=0 and start=0: q held.
- Start: start=1 in IDLE has priority over en.
  - Latches mode, amt, d, sin_l, sin_r and cnt; q is unchanged on that edge.
  - If cnt != 0: state -> RUN, rem <= cnt.
  - If cnt == 0: state stays IDLE and done <= 1 on that edge (empty burst).
- RUN:
  - busy=1. en, start, mode, amt, d and sin inputs are ignored; only latched values are used.
  - Each edge: q <= f(q, latched op), rem <= rem-1.
  - On the edge where rem==1: state -> IDLE and done <= 1. done is therefore high in the first cycle q shows the final value.
  - busy is high for exactly cnt cycles.
  - LOAD in a burst reloads the latched d each cycle. HOLD/reserved in a burst is a pure cnt-cycle delay.
- abort=1 in RUN: state -> IDLE on that edge; q takes no further op; no done pulse. abort has priority over the last-step done. abort in IDLE has no effect.
- done is a single-cycle pulse and is cleared on the next edge.
- start while busy is ignored; it is not queued.
- Reset mid-burst: immediate return to reset values; no done.
- cnt = 2^CNT_W-1 is legal. rem never underflows.

Decomposition:
- Package iiitb_usr_pkg holds:
  - mode constants (MODE_HOLD .. MODE_LOAD);
  - FSM state encoding (IDLE, RUN);
  - the 3-bit mode width constant.
- Sub-module iiitb_usr_shifter: purely combinational barrel unit mapping (q, mode, amt, sin_l, sin_r, d) to the next q.
  - Instanced once.
  - Shared by the single-step and burst paths.
- The top level holds the register, latched op, counter and FSM.

Test Plan (WIDTH=8):
- Async reset mid-cycle -> q=0x00, busy=0, done=0 before the next edge. Load 0x96 (mode 110, en=1) -> q=0x96 after 1 edge.
- q=0x96, en=1, mode ROL, amt=3 -> q=0xB4. Then ROR amt=3 -> q=0x96. amt=0 on any shift mode -> q unchanged.
- q=0x80, ASR amt=2 -> q=0xE0. q=0x00, SRL amt=3, sin_l=1 -> q=0xE0. q=0x00, SLL amt=2, sin_r=1 -> q=0x03.
- q=0x01, start, mode ROL, amt=1, cnt=3 -> q sequence 0x02, 0x04, 0x08; busy high 3 cycles; done high only with q=0x08. en pulses and mode changes during RUN have no effect.
- start with cnt=0 -> done pulse next cycle, busy never high, q unchanged.
- Burst cnt=5 cut short: abort after 2 steps -> q reflects 2 ops, no done. Separately, reset after 2 steps -> q=0, IDLE, no done.

Source files
------------

// File: rtl/iiitb_usr_pkg.sv
// Shared definitions for the universal shift register with burst engine.
// Holds the operation encoding, its width and the FSM state encoding.
// Imported by the barrel shifter and the top level.
package iiitb_usr_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SRL  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SLL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/iiitb_usr_shifter.sv
// Combinational barrel unit: next register value from (q, mode, amt, fills, d).
// Latency: 0 cycles (pure logic).
// Backpressure: none; the caller decides when the result is registered.
module iiitb_usr_shifter
    import iiitb_usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [MODE_W-1:0] mode,
    input  logic [AMT_W-1:0]  amt,
    input  logic              sin_l,
    input  logic              sin_r,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q_next
);

    // Double-width staging words: the upper/lower half supplies the fill bits,
    // so a single shift of the concatenation yields fill, sign or rotate results.
    logic [2*WIDTH-1:0] srl_w;
    logic [2*WIDTH-1:0] sll_w;
    logic [2*WIDTH-1:0] ror_w;
    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] asr_w;

    // Build every candidate result, then pick one by mode (reserved falls to hold).
    always_comb begin
        srl_w  = {{WIDTH{sin_l}}, q} >> amt;
        sll_w  = {q, {WIDTH{sin_r}}} << amt;
        ror_w  = {q, q} >> amt;
        rol_w  = {q, q} << amt;
        asr_w  = {{WIDTH{q[WIDTH-1]}}, q} >> amt;
        q_next = q;
        case (mode)
            MODE_SRL:  q_next = srl_w[WIDTH-1:0];
            MODE_SLL:  q_next = sll_w[2*WIDTH-1:WIDTH];
            MODE_ROR:  q_next = ror_w[WIDTH-1:0];
            MODE_ROL:  q_next = rol_w[2*WIDTH-1:WIDTH];
            MODE_ASR:  q_next = asr_w[WIDTH-1:0];
            MODE_LOAD: q_next = d;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/iiitb_usr_burst.sv
// Universal shift register with single-step ops and an autonomous burst engine.
// Latency: 1 cycle per op; a burst of cnt ops takes cnt cycles after the start edge.
// Backpressure: start/en are ignored while busy; abort cancels a burst without done.
module iiitb_usr_burst
    import iiitb_usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [AMT_W-1:0]  amt,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    input  logic              start,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              abort,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic              busy,
    output logic              done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic [MODE_W-1:0]  mode_l_q, mode_l_d;
    logic [AMT_W-1:0]   amt_l_q, amt_l_d;
    logic [WIDTH-1:0]   d_l_q, d_l_d;
    logic               sin_l_l_q, sin_l_l_d;
    logic               sin_r_l_q, sin_r_l_d;

    logic               run;
    logic [MODE_W-1:0]  sh_mode;
    logic [AMT_W-1:0]   sh_amt;
    logic [WIDTH-1:0]   sh_d;
    logic               sh_sin_l;
    logic               sh_sin_r;
    logic [WIDTH-1:0]   sh_q;

    // One shifter serves both paths: latched op during a burst, live inputs otherwise.
    always_comb begin
        run      = (state_q == RUN);
        sh_mode  = run ? mode_l_q  : mode;
        sh_amt   = run ? amt_l_q   : amt;
        sh_d     = run ? d_l_q     : d;
        sh_sin_l = run ? sin_l_l_q : sin_l;
        sh_sin_r = run ? sin_r_l_q : sin_r;
    end

    iiitb_usr_shifter #(.WIDTH(WIDTH)) u_shifter (
        .q      (q_q),
        .mode   (sh_mode),
        .amt    (sh_amt),
        .sin_l  (sh_sin_l),
        .sin_r  (sh_sin_r),
        .d      (sh_d),
        .q_next (sh_q)
    );

    // Next-state: start beats en in IDLE; abort beats the final-step done in RUN.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        mode_l_d  = mode_l_q;
        amt_l_d   = amt_l_q;
        d_l_d     = d_l_q;
        sin_l_l_d = sin_l_l_q;
        sin_r_l_d = sin_r_l_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_l_d  = mode;
                    amt_l_d   = amt;
                    d_l_d     = d;
                    sin_l_l_d = sin_l;
                    sin_r_l_d = sin_r;
                    if (cnt != '0) begin
                        state_d = RUN;
                        rem_d   = cnt;
                    end else begin
                        done_d  = 1'b1;
                    end
                end else if (en) begin
                    q_d = sh_q;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    q_d   = sh_q;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            q_q       <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            mode_l_q  <= '0;
            amt_l_q   <= '0;
            d_l_q     <= '0;
            sin_l_l_q <= 1'b0;
            sin_r_l_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            mode_l_q  <= mode_l_d;
            amt_l_q   <= amt_l_d;
            d_l_q     <= d_l_d;
            sin_l_l_q <= sin_l_l_d;
            sin_r_l_q <= sin_r_l_d;
        end
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = (state_q == RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_iiitb_usr_burst.sv
// Directed bench for iiitb_usr_burst with WIDTH=8, CNT_W=8.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Each scenario task carries its own inline comparisons.
module tb_iiitb_usr_burst;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [2:0] amt;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [7:0] cnt;
    logic       abort;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    iiitb_usr_burst #(.WIDTH(8), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .amt    (amt),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .start  (start),
        .cnt    (cnt),
        .abort  (abort),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; mode = 3'b000; amt = 0; d = 0; sin_l = 0; sin_r = 0;
        start = 0; cnt = 0; abort = 0;
    endtask

    task automatic step_op(input logic [2:0] m, input logic [2:0] a, input logic [7:0] dv,
                           input logic sl, input logic sr);
        en = 1; mode = m; amt = a; d = dv; sin_l = sl; sin_r = sr;
        tick();
        en = 0;
    endtask

    task automatic test_reset();
        step_op(3'b110, 0, 8'h5A, 0, 0);
        total++;
        if (q !== 8'h5A) begin bad++; $display("FAIL pre_reset_load q=%h exp=5a", q); end
        #3 reset = 1;
        #1;
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL async_reset q=%h busy=%b done=%b exp=00/0/0", q, busy, done);
        end
        @(negedge clk) reset = 0;
        @(posedge clk); #1;
        step_op(3'b110, 5, 8'h96, 0, 0);
        total++;
        if (q !== 8'h96) begin bad++; $display("FAIL load_96 q=%h exp=96", q); end
        total++;
        if (sout_l !== 1'b1 || sout_r !== 1'b0) begin
            bad++; $display("FAIL serial_out sout_l=%b sout_r=%b exp=1/0", sout_l, sout_r);
        end
    endtask

    task automatic test_rotate();
        step_op(3'b100, 3, 0, 0, 0);
        total++;
        if (q !== 8'hB4) begin bad++; $display("FAIL rol3 q=%h exp=b4", q); end
        step_op(3'b011, 3, 0, 0, 0);
        total++;
        if (q !== 8'h96) begin bad++; $display("FAIL ror3 q=%h exp=96", q); end
        step_op(3'b001, 0, 0, 1, 1);
        total++;
        if (q !== 8'h96) begin bad++; $display("FAIL srl_amt0 q=%h exp=96", q); end
        step_op(3'b100, 0, 0, 1, 1);
        total++;
        if (q !== 8'h96) begin bad++; $display("FAIL rol_amt0 q=%h exp=96", q); end
        en = 0; mode = 3'b110; d = 8'hFF;
        tick();
        total++;
        if (q !== 8'h96) begin bad++; $display("FAIL hold_en0 q=%h exp=96", q); end
        step_op(3'b111, 4, 8'h11, 1, 1);
        total++;
        if (q !== 8'h96) begin bad++; $display("FAIL reserved q=%h exp=96", q); end
    endtask

    task automatic test_shift();
        step_op(3'b110, 0, 8'h80, 0, 0);
        step_op(3'b101, 2, 0, 0, 0);
        total++;
        if (q !== 8'hE0) begin bad++; $display("FAIL asr2 q=%h exp=e0", q); end
        step_op(3'b110, 0, 8'h00, 0, 0);
        step_op(3'b001, 3, 0, 1, 0);
        total++;
        if (q !== 8'hE0) begin bad++; $display("FAIL srl3_fill q=%h exp=e0", q); end
        step_op(3'b110, 0, 8'h00, 0, 0);
        step_op(3'b010, 2, 0, 0, 1);
        total++;
        if (q !== 8'h03) begin bad++; $display("FAIL sll2_fill q=%h exp=03", q); end
        step_op(3'b110, 0, 8'h81, 0, 0);
        step_op(3'b010, 7, 0, 0, 0);
        total++;
        if (q !== 8'h80) begin bad++; $display("FAIL sll7 q=%h exp=80", q); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_q [3];
        int busy_cycles;
        exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h08;
        busy_cycles = 0;
        step_op(3'b110, 0, 8'h01, 0, 0);
        start = 1; mode = 3'b100; amt = 1; cnt = 3; en = 0;
        tick();
        start = 0;
        total++;
        if (q !== 8'h01 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL burst_start q=%h busy=%b done=%b exp=01/1/0", q, busy, done);
        end
        if (busy) busy_cycles++;
        // Noise on the live inputs must be ignored while running.
        en = 1; mode = 3'b110; d = 8'hFF; amt = 5; start = 1; cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (q !== exp_q[i] || done !== (i == 2)) begin
                bad++; $display("FAIL burst_step%0d q=%h done=%b exp=%h/%b", i, q, done, exp_q[i], (i == 2));
            end
            if (busy) busy_cycles++;
            if (i == 1) begin en = 0; start = 0; end
        end
        total++;
        if (busy_cycles != 3) begin bad++; $display("FAIL burst_busy_cycles got=%0d exp=3", busy_cycles); end
        idle_inputs();
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h08) begin
            bad++; $display("FAIL burst_after q=%h busy=%b done=%b exp=08/0/0", q, busy, done);
        end
    endtask

    task automatic test_empty_burst();
        start = 1; cnt = 0; mode = 3'b110; d = 8'hAA;
        tick();
        start = 0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h08) begin
            bad++; $display("FAIL empty_burst q=%h busy=%b done=%b exp=08/0/1", q, busy, done);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h08) begin
            bad++; $display("FAIL empty_burst_clear q=%h busy=%b done=%b exp=08/0/0", q, busy, done);
        end
    endtask

    task automatic test_load_burst();
        start = 1; cnt = 2; mode = 3'b110; d = 8'h3C;
        tick();
        start = 0; d = 8'h00; mode = 3'b001;
        tick();
        tick();
        total++;
        if (q !== 8'h3C || done !== 1'b1) begin
            bad++; $display("FAIL load_burst q=%h done=%b exp=3c/1", q, done);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_abort();
        step_op(3'b110, 0, 8'h01, 0, 0);
        abort = 1;
        tick();
        total++;
        if (q !== 8'h01 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle q=%h busy=%b exp=01/0", q, busy); end
        abort = 0;
        start = 1; mode = 3'b100; amt = 1; cnt = 5;
        tick();
        start = 0;
        tick(); tick();
        abort = 1;
        tick();
        abort = 0;
        total++;
        if (q !== 8'h04 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_mid q=%h busy=%b done=%b exp=04/0/0", q, busy, done);
        end
        tick();
        total++;
        if (q !== 8'h04 || done !== 1'b0) begin bad++; $display("FAIL abort_after q=%h done=%b exp=04/0", q, done); end
        start = 1; cnt = 1;
        tick();
        start = 0; abort = 1;
        tick();
        abort = 0;
        total++;
        if (q !== 8'h04 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_last q=%h busy=%b done=%b exp=04/0/0", q, busy, done);
        end
    endtask

    task automatic test_reset_mid_burst();
        step_op(3'b110, 0, 8'h01, 0, 0);
        start = 1; mode = 3'b100; amt = 1; cnt = 5;
        tick();
        start = 0;
        tick(); tick();
        total++;
        if (q !== 8'h04 || busy !== 1'b1) begin bad++; $display("FAIL pre_reset_burst q=%h busy=%b exp=04/1", q, busy); end
        #2 reset = 1;
        #1;
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid_burst q=%h busy=%b done=%b exp=00/0/0", q, busy, done);
        end
        @(negedge clk) reset = 0;
        tick();
        tick();
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL after_reset_burst q=%h busy=%b done=%b exp=00/0/0", q, busy, done);
        end
    endtask

    task automatic test_max_count();
        int busy_cycles;
        int guard;
        busy_cycles = 0;
        guard = 0;
        step_op(3'b110, 0, 8'h5A, 0, 0);
        start = 1; mode = 3'b000; cnt = 8'hFF;
        tick();
        start = 0;
        while (busy && guard < 400) begin
            busy_cycles++;
            guard++;
            tick();
        end
        total++;
        if (busy_cycles != 255 || done !== 1'b1 || q !== 8'h5A) begin
            bad++; $display("FAIL max_count busy_cycles=%0d done=%b q=%h exp=255/1/5a", busy_cycles, done, q);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        #12 reset = 0;
        tick();
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_state q=%h busy=%b done=%b exp=00/0/0", q, busy, done);
        end
        test_reset();
        test_rotate();
        test_shift();
        test_burst();
        test_empty_burst();
        test_load_burst();
        test_abort();
        test_reset_mid_burst();
        test_max_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
